// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and FSM state type for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection for fetch_ctrl: redirect target (word aligned), +4 with silent wrap, or hold.
module fetch_pc_gen
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned XLEN   = 32
) (
  input  logic [ADDR_W+1:0] pc_q,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              advance,
  output logic [ADDR_W+1:0] pc_d
);

  localparam int unsigned PW = ADDR_W + 2;

  // Target bits above the PC width and the byte offset are deliberately dropped.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^{redirect_pc[XLEN-1:PW], redirect_pc[1:0]};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[PW-1:2], 2'b00};
    end else if (advance) begin
      pc_d = pc_q + PW'(PC_INC);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers fetched words into a valid/ready slot,
// handles redirect/flush and halt/resume. Optional counters with FETCH_PERF_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 11,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_instr,
  input  logic              halt_req,
  output logic              halted,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned   PW         = ADDR_W + 2;
  localparam logic [PW-1:0] RESET_PC_A = {RESET_PC[PW-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic [PW-1:0]   out_pc_q, out_pc_d;
  logic            fetch_ok;
  logic            load;

  assign fetch_ok = (state_q == S_RUN) & ~halt_req & ~redirect_valid;
  assign load     = fetch_ok & (~out_valid_q | out_ready);

  fetch_pc_gen #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) u_pc_gen (
    .pc_q           (pc_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (load),
    .pc_d           (pc_d)
  );

  // Redirect flushes the slot even if decode takes it this cycle; instr/pc are left stale.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_instr_d = imem_instr;
      out_pc_d    = pc_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (halt_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!halt_req)        state_d = S_RUN;
        else if (!out_valid_q) state_d = S_HALT;
      end
      S_HALT: begin
        if (!halt_req) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC_A;
      out_valid_q <= 1'b0;
      out_instr_q <= XLEN'(NOP_INSTR);
      out_pc_q    <= RESET_PC_A;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign imem_addr = pc_q[PW-1:2];
  assign halted    = (state_q == S_HALT);
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = XLEN'(out_pc_q);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (load)                      perf_fetch_d = perf_fetch_q + 32'd1;
    if (out_valid_q && !out_ready) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
